// File: rtl/id_stage_if.sv
// IF/ID, write-back and ID/EX signal bundle for the decode stage.
// With ID_ILLEGAL_DETECT_EN defined the bundle carries id_ex_reg_illegal.
interface id_stage_if;
   logic [31:0] if_id_reg_pc;
   logic [31:0] if_id_reg_inst;
   logic        ex_stage_flush;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        id_stage_stall;
   logic [31:0] id_ex_reg_pc;
   logic [31:0] id_ex_reg_rs1_data;
   logic [31:0] id_ex_reg_rs2_data;
   logic [31:0] id_ex_reg_imm;
   logic [4:0]  id_ex_reg_rs1;
   logic [4:0]  id_ex_reg_rs2;
   logic [4:0]  id_ex_reg_rd;
   logic [2:0]  id_ex_reg_funct3;
   logic        id_ex_reg_funct7b5;
   logic [9:0]  id_ex_reg_ctrl;
`ifdef ID_ILLEGAL_DETECT_EN
   logic        id_ex_reg_illegal;
`endif

   modport master (
`ifdef ID_ILLEGAL_DETECT_EN
      input  id_ex_reg_illegal,
`endif
      output if_id_reg_pc, if_id_reg_inst, ex_stage_flush,
      output wb_we, wb_rd, wb_data,
      input  id_stage_stall, id_ex_reg_pc,
      input  id_ex_reg_rs1_data, id_ex_reg_rs2_data, id_ex_reg_imm,
      input  id_ex_reg_rs1, id_ex_reg_rs2, id_ex_reg_rd,
      input  id_ex_reg_funct3, id_ex_reg_funct7b5, id_ex_reg_ctrl
   );

   modport slave (
`ifdef ID_ILLEGAL_DETECT_EN
      output id_ex_reg_illegal,
`endif
      input  if_id_reg_pc, if_id_reg_inst, ex_stage_flush,
      input  wb_we, wb_rd, wb_data,
      output id_stage_stall, id_ex_reg_pc,
      output id_ex_reg_rs1_data, id_ex_reg_rs2_data, id_ex_reg_imm,
      output id_ex_reg_rs1, id_ex_reg_rs2, id_ex_reg_rd,
      output id_ex_reg_funct3, id_ex_reg_funct7b5, id_ex_reg_ctrl
   );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: register file, decode, load-use stall, ID/EX register.
// Optional ID_ILLEGAL_DETECT_EN adds the id_ex_reg_illegal output.
module id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic      clk,
   input  logic      rst,
   id_stage_if.slave bus
);

   logic [31:0] inst;
   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rs1f, rs2f, rdf;

   assign inst   = bus.if_id_reg_inst;
   assign opcode = inst[6:0];
   assign f3     = inst[14:12];
   assign f7     = inst[31:25];
   assign rs1f   = inst[19:15];
   assign rs2f   = inst[24:20];
   assign rdf    = inst[11:7];

   logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

   assign i_imm = {{20{inst[31]}}, inst[31:20]};
   assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign b_imm = {{19{inst[31]}}, inst[31], inst[7],
                   inst[30:25], inst[11:8], 1'b0};
   assign u_imm = {inst[31:12], 12'b0};
   assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12],
                   inst[20], inst[30:21], 1'b0};

   logic is_lui, is_auipc, is_jal, is_jalr;
   logic is_br, is_ld, is_st, is_opi, is_op;

   assign is_lui   = opcode == 7'b0110111;
   assign is_auipc = opcode == 7'b0010111;
   assign is_jal   = opcode == 7'b1101111;
   assign is_jalr  = opcode == 7'b1100111;
   assign is_br    = opcode == 7'b1100011;
   assign is_ld    = opcode == 7'b0000011;
   assign is_st    = opcode == 7'b0100011;
   assign is_opi   = opcode == 7'b0010011;
   assign is_op    = opcode == 7'b0110011;

   logic op_ok, opi_ok, ld_ok, st_ok, br_ok;

   assign op_ok  = (f7 == 7'h00) |
                   ((f7 == 7'h20) & ((f3 == 3'b000) | (f3 == 3'b101)));
   assign opi_ok = (f3 == 3'b001) ? (f7 == 7'h00) :
                   (f3 == 3'b101) ? ((f7 == 7'h00) | (f7 == 7'h20)) :
                   1'b1;
   assign ld_ok  = (f3 != 3'b011) & (f3 != 3'b110) & (f3 != 3'b111);
   assign st_ok  = ~f3[2] & ~(f3[1] & f3[0]);
   assign br_ok  = f3[2:1] != 2'b01;

   // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src,
   //         branch, jal, jalr, lui, auipc}
   logic [9:0]  ctrl_d;
   logic [31:0] imm_d;
   logic        use1, use2, legal;

   always_comb begin
      ctrl_d = '0;
      imm_d  = '0;
      use1   = 1'b0;
      use2   = 1'b0;
      legal  = 1'b0;
      unique case (1'b1)
         is_lui: begin
            ctrl_d = 10'b1000100010;
            imm_d  = u_imm;
            legal  = 1'b1;
         end
         is_auipc: begin
            ctrl_d = 10'b1000100001;
            imm_d  = u_imm;
            legal  = 1'b1;
         end
         is_jal: begin
            ctrl_d = 10'b1000001000;
            imm_d  = j_imm;
            legal  = 1'b1;
         end
         is_jalr: begin
            ctrl_d = 10'b1000100100;
            imm_d  = i_imm;
            use1   = 1'b1;
            legal  = 1'b1;
         end
         is_br: begin
            ctrl_d = 10'b0000010000;
            imm_d  = b_imm;
            use1   = 1'b1;
            use2   = 1'b1;
            legal  = br_ok;
         end
         is_ld: begin
            ctrl_d = 10'b1101100000;
            imm_d  = i_imm;
            use1   = 1'b1;
            legal  = ld_ok;
         end
         is_st: begin
            ctrl_d = 10'b0010100000;
            imm_d  = s_imm;
            use1   = 1'b1;
            use2   = 1'b1;
            legal  = st_ok;
         end
         is_opi: begin
            ctrl_d = 10'b1000100000;
            imm_d  = i_imm;
            use1   = 1'b1;
            legal  = opi_ok;
         end
         is_op: begin
            ctrl_d = 10'b1000000000;
            use1   = 1'b1;
            use2   = 1'b1;
            legal  = op_ok;
         end
         default: ;
      endcase
   end

   logic [31:0] rf [32];
   logic [31:0] rs1_data, rs2_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (bus.wb_we && bus.wb_rd != 5'd0) begin
         rf[bus.wb_rd] <= bus.wb_data;
      end
   end

   // Same-cycle write-back is visible to the reading instruction.
   always_comb begin
      rs1_data = rf[rs1f];
      rs2_data = rf[rs2f];
      if (bus.wb_we && bus.wb_rd == rs1f) rs1_data = bus.wb_data;
      if (bus.wb_we && bus.wb_rd == rs2f) rs2_data = bus.wb_data;
      if (rs1f == 5'd0) rs1_data = '0;
      if (rs2f == 5'd0) rs2_data = '0;
   end

   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_f3;
   logic        ex_f7b5;
   logic [9:0]  ex_ctrl;
   logic        ex_ill;
   logic        stall, squash, bubble;

   assign stall = ex_ctrl[8] & (ex_rd != 5'd0) &
                  ((use1 & (rs1f == ex_rd)) |
                   (use2 & (rs2f == ex_rd))) &
                  ~bus.ex_stage_flush;
   assign squash = bus.ex_stage_flush | stall;
   assign bubble = squash | ~legal;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_pc       <= RESET_PC;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_f3       <= '0;
         ex_f7b5     <= 1'b0;
         ex_ctrl     <= '0;
         ex_ill      <= 1'b0;
      end else begin
         ex_pc       <= bus.if_id_reg_pc;
         ex_rs1_data <= rs1_data;
         ex_rs2_data <= rs2_data;
         ex_imm      <= imm_d;
         ex_rs1      <= use1 ? rs1f : 5'd0;
         ex_rs2      <= use2 ? rs2f : 5'd0;
         ex_rd       <= (bubble | ~ctrl_d[9]) ? 5'd0 : rdf;
         ex_f3       <= f3;
         ex_f7b5     <= inst[30];
         ex_ctrl     <= bubble ? 10'd0 : ctrl_d;
         ex_ill      <= ~squash & ~legal;
      end
   end

   assign bus.id_stage_stall     = stall;
   assign bus.id_ex_reg_pc       = ex_pc;
   assign bus.id_ex_reg_rs1_data = ex_rs1_data;
   assign bus.id_ex_reg_rs2_data = ex_rs2_data;
   assign bus.id_ex_reg_imm      = ex_imm;
   assign bus.id_ex_reg_rs1      = ex_rs1;
   assign bus.id_ex_reg_rs2      = ex_rs2;
   assign bus.id_ex_reg_rd       = ex_rd;
   assign bus.id_ex_reg_funct3   = ex_f3;
   assign bus.id_ex_reg_funct7b5 = ex_f7b5;
   assign bus.id_ex_reg_ctrl     = ex_ctrl;
`ifdef ID_ILLEGAL_DETECT_EN
   assign bus.id_ex_reg_illegal  = ex_ill;
`else
   logic unused_ill;
   assign unused_ill = ex_ill;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: vector table, directed hazard sequences and
// random instructions against a spec-level decode/register-file model.
module tb_id_stage;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   id_stage_if bus ();

   id_stage #(.RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [9:0]  ctrl;
      logic [31:0] imm;
      logic        u1;
      logic        u2;
      logic        legal;
   } dec_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] imm;
      logic [9:0]  ctrl;
      logic [4:0]  rd;
      bit          chk_imm;
   } vec_t;

   // model state
   logic [31:0] mreg [32];
   logic [31:0] m_pc, m_d1, m_d2, m_imm;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic [2:0]  m_f3;
   logic        m_f7, m_bub, m_ill, m_u1, m_u2;
   logic [9:0]  m_ctrl;
   logic        m_stall;
   logic        seen_stall;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic dec_t mdec(input logic [31:0] in);
      dec_t d;
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = in[14:12];
      f7 = in[31:25];
      d = '0;
      case (in[6:0])
         7'h37: begin
            d.ctrl = 10'b1000100010; d.imm = {in[31:12], 12'h000};
            d.legal = 1;
         end
         7'h17: begin
            d.ctrl = 10'b1000100001; d.imm = {in[31:12], 12'h000};
            d.legal = 1;
         end
         7'h6F: begin
            d.ctrl = 10'b1000001000;
            d.imm = 32'($signed({in[31], in[19:12], in[20],
                                 in[30:21], 1'b0}));
            d.legal = 1;
         end
         7'h67: begin
            d.ctrl = 10'b1000100100; d.imm = 32'($signed(in[31:20]));
            d.u1 = 1; d.legal = 1;
         end
         7'h63: begin
            d.ctrl = 10'b0000010000;
            d.imm = 32'($signed({in[31], in[7], in[30:25],
                                 in[11:8], 1'b0}));
            d.u1 = 1; d.u2 = 1; d.legal = (f3 != 2) && (f3 != 3);
         end
         7'h03: begin
            d.ctrl = 10'b1101100000; d.imm = 32'($signed(in[31:20]));
            d.u1 = 1; d.legal = f3 inside {0, 1, 2, 4, 5};
         end
         7'h23: begin
            d.ctrl = 10'b0010100000;
            d.imm = 32'($signed({in[31:25], in[11:7]}));
            d.u1 = 1; d.u2 = 1; d.legal = f3 inside {0, 1, 2};
         end
         7'h13: begin
            d.ctrl = 10'b1000100000; d.imm = 32'($signed(in[31:20]));
            d.u1 = 1;
            if (f3 == 1) d.legal = (f7 == 0);
            else if (f3 == 5) d.legal = (f7 == 0) || (f7 == 7'h20);
            else d.legal = 1;
         end
         7'h33: begin
            d.ctrl = 10'b1000000000; d.imm = 0;
            d.u1 = 1; d.u2 = 1;
            d.legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
         end
         default: d.legal = 0;
      endcase
      if (!d.legal) d.ctrl = 0;
      return d;
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] r);
      if (r == 0) return 0;
      if (bus.wb_we && bus.wb_rd == r) return bus.wb_data;
      return mreg[r];
   endfunction

   // One clock: check stall mid-cycle, advance model, check ID/EX.
   task automatic cycle();
      dec_t d;
      logic [31:0] in, r1, r2;
      logic st;
      in = bus.if_id_reg_inst;
      d  = mdec(in);
      st = m_ctrl[8] && m_rd != 0 && !bus.ex_stage_flush &&
           ((d.u1 && in[19:15] == m_rd) || (d.u2 && in[24:20] == m_rd));
      r1 = mread(in[19:15]);
      r2 = mread(in[24:20]);
      @(negedge clk);
      seen_stall = bus.id_stage_stall;
      if (!rst) chk("stall", {31'd0, bus.id_stage_stall}, {31'd0, st});
      m_stall = st;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) mreg[i] = 0;
         m_pc = RPC; m_d1 = 0; m_d2 = 0; m_imm = 0;
         m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0;
         m_ctrl = 0; m_ill = 0; m_bub = 0; m_u1 = 1; m_u2 = 1;
         m_stall = 0;
      end else begin
         if (bus.wb_we && bus.wb_rd != 0) mreg[bus.wb_rd] = bus.wb_data;
         m_bub  = bus.ex_stage_flush || st || !d.legal;
         m_ctrl = m_bub ? 10'd0 : d.ctrl;
         m_rd   = (m_bub || !d.ctrl[9]) ? 5'd0 : in[11:7];
         m_ill  = !(bus.ex_stage_flush || st) && !d.legal;
         m_pc   = bus.if_id_reg_pc;
         m_imm  = d.imm;
         m_d1 = r1; m_d2 = r2;
         m_rs1 = in[19:15]; m_rs2 = in[24:20];
         m_u1 = d.u1; m_u2 = d.u2;
         m_f3 = in[14:12]; m_f7 = in[30];
      end
      #1;
      chk("ctrl", {22'd0, bus.id_ex_reg_ctrl}, {22'd0, m_ctrl});
      if (m_bub || m_ctrl[9] || rst)
         chk("rd", {27'd0, bus.id_ex_reg_rd}, {27'd0, m_rd});
`ifdef ID_ILLEGAL_DETECT_EN
      chk("illegal", {31'd0, bus.id_ex_reg_illegal}, {31'd0, m_ill});
`endif
      if (rst || !m_bub) begin
         chk("pc", bus.id_ex_reg_pc, m_pc);
         chk("imm", bus.id_ex_reg_imm, m_imm);
         chk("funct3", {29'd0, bus.id_ex_reg_funct3}, {29'd0, m_f3});
         chk("f7b5", {31'd0, bus.id_ex_reg_funct7b5}, {31'd0, m_f7});
         if (m_u1) begin
            chk("rs1", {27'd0, bus.id_ex_reg_rs1}, {27'd0, m_rs1});
            chk("rs1_data", bus.id_ex_reg_rs1_data, m_d1);
         end
         if (m_u2) begin
            chk("rs2", {27'd0, bus.id_ex_reg_rs2}, {27'd0, m_rs2});
            chk("rs2_data", bus.id_ex_reg_rs2_data, m_d2);
         end
      end
   endtask

   task automatic drive(input logic [31:0] in, input logic fl);
      bus.if_id_reg_inst = in;
      bus.ex_stage_flush = fl;
   endtask

   function automatic logic [31:0] rnd_inst();
      logic [31:0] x;
      int k;
      x = $urandom;
      k = $urandom_range(0, 9);
      x[19:15] = 5'($urandom_range(0, 7));
      x[24:20] = 5'($urandom_range(0, 7));
      x[11:7]  = 5'($urandom_range(0, 7));
      case (k)
         0: x[6:0] = 7'h37;
         1: x[6:0] = 7'h17;
         2: x[6:0] = 7'h6F;
         3: x[6:0] = 7'h67;
         4: x[6:0] = 7'h63;
         5: x[6:0] = 7'h03;
         6: x[6:0] = 7'h23;
         7: begin
            x[6:0] = 7'h13;
            if ($urandom_range(0, 3) != 0)
               x[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20;
         end
         8: begin
            x[6:0] = 7'h33;
            if ($urandom_range(0, 3) != 0)
               x[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20;
         end
         default: ;
      endcase
      return x;
   endfunction

   vec_t vt [13];

   initial begin
      vt[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 10'h220, 5'd1, 1'b1};
      vt[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 10'h010, 5'd0, 1'b1};
      vt[2]  = '{32'h123450B7, 32'h12345000, 10'h222, 5'd1, 1'b1};
      vt[3]  = '{32'hFFFFF117, 32'hFFFFF000, 10'h221, 5'd2, 1'b1};
      vt[4]  = '{32'h008000EF, 32'h00000008, 10'h208, 5'd1, 1'b1};
      vt[5]  = '{32'h004100E7, 32'h00000004, 10'h224, 5'd1, 1'b1};
      vt[6]  = '{32'hFF80A383, 32'hFFFFFFF8, 10'h360, 5'd7, 1'b1};
      vt[7]  = '{32'h0020A623, 32'h0000000C, 10'h0A0, 5'd0, 1'b1};
      vt[8]  = '{32'h402081B3, 32'h00000000, 10'h200, 5'd3, 1'b1};
      vt[9]  = '{32'h0000007F, 32'h00000000, 10'h000, 5'd0, 1'b0};
      vt[10] = '{32'h020081B3, 32'h00000000, 10'h000, 5'd0, 1'b0};
      vt[11] = '{32'h002090E3, 32'h00000800, 10'h010, 5'd0, 1'b1};
      vt[12] = '{32'h4030D093, 32'h00000403, 10'h220, 5'd1, 1'b1};

      for (int i = 0; i < 32; i++) mreg[i] = 0;
      m_ctrl = 0; m_rd = 0; m_stall = 0;
      bus.if_id_reg_pc = 32'h0000_0200;
      bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
      drive(32'h00500093, 1'b0);

      // reset
      rst = 1;
      cycle();
      cycle();
      chk("reset_pc", bus.id_ex_reg_pc, RPC);
      chk("reset_ctrl", {22'd0, bus.id_ex_reg_ctrl}, 32'd0);
      chk("reset_imm", bus.id_ex_reg_imm, 32'd0);
      chk("reset_stall", {31'd0, bus.id_stage_stall}, 32'd0);
      rst = 0;

      // decode vectors
      for (int i = 0; i < 13; i++) begin
         drive(vt[i].inst, 1'b0);
         bus.if_id_reg_pc = 32'h1000 + 32'(i * 4);
         cycle();
         chk("vec_ctrl", {22'd0, bus.id_ex_reg_ctrl}, {22'd0, vt[i].ctrl});
         if (vt[i].ctrl[9] || vt[i].ctrl == 0)
            chk("vec_rd", {27'd0, bus.id_ex_reg_rd}, {27'd0, vt[i].rd});
         if (vt[i].chk_imm)
            chk("vec_imm", bus.id_ex_reg_imm, vt[i].imm);
      end
`ifdef ID_ILLEGAL_DETECT_EN
      drive(32'h0000007F, 1'b0);
      cycle();
      chk("illegal_flag", {31'd0, bus.id_ex_reg_illegal}, 32'd1);
`endif

      // write-through
      bus.wb_we = 1; bus.wb_rd = 5; bus.wb_data = 32'hDEADBEEF;
      drive(32'h005281B3, 1'b0);
      cycle();
      chk("wt_rs1", bus.id_ex_reg_rs1_data, 32'hDEADBEEF);
      chk("wt_rs2", bus.id_ex_reg_rs2_data, 32'hDEADBEEF);
      bus.wb_rd = 0; bus.wb_data = 32'h00001234;
      drive(32'h000001B3, 1'b0);
      cycle();
      chk("x0_bypass", bus.id_ex_reg_rs1_data, 32'd0);
      bus.wb_we = 0;
      cycle();
      chk("x0_read", bus.id_ex_reg_rs1_data, 32'd0);

      // load-use
      drive(32'h0000A103, 1'b0);
      cycle();
      drive(32'h002101B3, 1'b0);
      cycle();
      chk("lu_stall", {31'd0, seen_stall}, 32'd1);
      chk("lu_bubble", {22'd0, bus.id_ex_reg_ctrl}, 32'd0);
      cycle();
      chk("lu_release", {31'd0, seen_stall}, 32'd0);
      chk("lu_issue", {22'd0, bus.id_ex_reg_ctrl}, 32'h200);
      chk("lu_issue_rd", {27'd0, bus.id_ex_reg_rd}, 32'd3);
      drive(32'h0000A103, 1'b0);
      cycle();
      drive(32'h004201B3, 1'b0);
      cycle();
      chk("nolu_stall", {31'd0, seen_stall}, 32'd0);
      chk("nolu_ctrl", {22'd0, bus.id_ex_reg_ctrl}, 32'h200);

      // flush over stall
      drive(32'h0000A103, 1'b0);
      cycle();
      drive(32'h002101B3, 1'b1);
      cycle();
      chk("fl_stall", {31'd0, seen_stall}, 32'd0);
      chk("fl_ctrl", {22'd0, bus.id_ex_reg_ctrl}, 32'd0);
      drive(32'h00000013, 1'b0);
      cycle();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         if (!m_stall) begin
            bus.if_id_reg_inst = rnd_inst();
            bus.if_id_reg_pc = bus.if_id_reg_pc + 4;
         end
         bus.ex_stage_flush = ($urandom_range(0, 9) == 0);
         bus.wb_we   = $urandom_range(0, 1);
         bus.wb_rd   = 5'($urandom_range(0, 7));
         bus.wb_data = $urandom;
         cycle();
      end

      // reset mid-run clears the register file
      bus.wb_we = 0;
      bus.ex_stage_flush = 0;
      rst = 1;
      cycle();
      rst = 0;
      for (int r = 1; r < 8; r++) begin
         drive({7'd0, 5'(r), 5'(r), 3'd0, 5'd3, 7'h33}, 1'b0);
         cycle();
         chk("clr_rs1", bus.id_ex_reg_rs1_data, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage RV32I pipeline. It consumes the IF/ID register (`if_id_reg_pc`, `if_id_reg_inst`) and decodes the instruction. It reads a 32x32 register file that has a write-back port, and registers operands, immediate and control into the ID/EX register. It detects load-use hazards, drives `id_stage_stall` back to the fetch stage, and inserts bubbles on stall or `ex_stage_flush`.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: value of `id_ex_reg_pc` after reset.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_id_reg_pc`  in  32  PC of the instruction in decode.
- `if_id_reg_inst`  in  32  instruction in decode; 32'h00000013 is a NOP.
- `ex_stage_flush`  in  1  branch/jump taken in EX; squash decode.
- `wb_we`  in  1  register-file write enable.
- `wb_rd`  in  5  write-back destination register.
- `wb_data`  in  32  write-back data.
- `id_stage_stall`  out  1  combinational; holds PC and IF/ID.
- `id_ex_reg_pc`  out  32  registered PC.
- `id_ex_reg_rs1_data`, `id_ex_reg_rs2_data`  out  32 each  registered operands.
- `id_ex_reg_imm`  out  32  sign-extended immediate.
- `id_ex_reg_rs1`, `id_ex_reg_rs2`, `id_ex_reg_rd`  out  5 each  register indices, used for EX forwarding.
- `id_ex_reg_funct3`  out  3.
- `id_ex_reg_funct7b5`  out  1  inst[30].
- `id_ex_reg_ctrl`  out  10  control bits {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jal, jalr, lui, auipc}.
- `id_ex_reg_illegal`  out  1  present only with `ID_ILLEGAL_DETECT_EN`.

## Operation
- **Decode by opcode inst[6:0]:**
  - LUI 0110111 (U)
  - AUIPC 0010111 (U)
  - JAL 1101111 (J)
  - JALR 1100111 (I)
  - BRANCH 1100011 (B)
  - LOAD 0000011 (I)
  - STORE 0100011 (S)
  - OP-IMM 0010011 (I)
  - OP 0110011 (no immediate, imm=0)
  - Any other opcode produces ctrl=0, i.e. a bubble.
- **Immediates:** sign-extended from inst[31].
  - B and J immediates have bit 0 = 0.
  - U immediate is {inst[31:12], 12'b0}.
- **rs2 usage:** rs2 counts as "used" only for BRANCH, STORE and OP.
- **rs1 usage:** rs1 counts as "used" for all formats except LUI, AUIPC and JAL.
- **Register file:**
  - x0 reads 0; writes to x0 are ignored.
  - Writes happen on the rising edge when `wb_we`.
  - Write-through bypass: if `wb_we` and `wb_rd`==rs (nonzero), the read returns `wb_data` in the same cycle.
- **Load-use hazard:** `id_stage_stall` = `id_ex_reg_ctrl.mem_read` & (`id_ex_reg_rd`≠0) & ((rs1 used & rs1==`id_ex_reg_rd`) | (rs2 used & rs2==`id_ex_reg_rd`)) & ~`ex_stage_flush`.
- **ID/EX update priority, every edge:**
  1. `rst`: all outputs 0, except `id_ex_reg_pc`=`RESET_PC`.
  2. `ex_stage_flush`: load a bubble (ctrl=0, rd=0, illegal=0). PC and data fields are don't-care but are loaded from IF/ID.
  3. `id_stage_stall`: load a bubble. IF/ID holds, so the same instruction re-decodes next cycle.
  4. Otherwise: load the decoded instruction.
- **Reset mid-operation:** discards all state, including register-file contents (all cleared to 0).

## Timing
- Decode-to-ID/EX latency is 1 cycle.
- `id_stage_stall` is combinational from the ID/EX register and IF/ID; no registered path.
- A load-use stall lasts exactly 1 cycle, because the bubble clears `mem_read` in ID/EX.
- Flush and stall in the same cycle: flush wins and stall is forced to 0, so the fetch stage redirects.
- A write-back and a read of the same register in one cycle returns the new value.

## Configuration
- `ID_ILLEGAL_DETECT_EN` defined:
  - An unknown opcode, or an invalid funct3/funct7 for OP, OP-IMM shifts, LOAD, STORE or BRANCH, sets `id_ex_reg_illegal`=1 with ctrl=0.
  - `id_ex_reg_illegal` is cleared by bubbles and by reset.
- Undefined:
  - The port is absent.
  - Illegal encodings decode silently as bubbles.

## Test plan
- **Reset:** assert `rst` 2 cycles with inst=32'h00500093 → all ID/EX outputs 0, `id_ex_reg_pc`=`RESET_PC`, stall=0.
- **ADDI decode:** inst 32'hFFF00093 (addi x1,x0,-1) → next cycle imm=32'hFFFFFFFF, rd=1, reg_write=1, alu_src=1.
- **Write-through:** `wb_we`=1, `wb_rd`=5, `wb_data`=32'hDEADBEEF while inst is add x3,x5,x5 → rs1_data = rs2_data = 32'hDEADBEEF. A write to x0 followed by a read of x0 returns 0.
- **Load-use:** lw x2,0(x1) then add x3,x2,x2 → stall=1 for exactly 1 cycle, one bubble (ctrl=0) in ID/EX, then add is issued. The same sequence with add x3,x4,x4 gives no stall.
- **Flush over stall:** the load-use condition and `ex_stage_flush`=1 in the same cycle → stall=0, ID/EX ctrl=0 next cycle.
- **B and J immediates:** inst 32'hFE000EE3 (beq x0,x0,-4) → imm=32'hFFFFFFFC, branch=1. With `ID_ILLEGAL_DETECT_EN`, inst 32'h0000007F → illegal=1, ctrl=0.
